sequence_player: RTL

//  Plays the stored color sequence to the player during the FPGA-turn phase of the Genius game.

---
 rtl/genius_pkg.sv | 22 ++
 rtl/sequence_player_phase_timer.sv | 36 +++
 rtl/sequence_player.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/genius_pkg.sv
// Shared Genius game definitions: color width, player FSM states
// and the color-to-LED decode used by every game block.
package genius_pkg;

    localparam int COLOR_W = 2;

    typedef enum logic [2:0] {
        SP_IDLE = 3'd0,
        SP_ADDR = 3'd1,
        SP_WAIT = 3'd2,
        SP_SHOW = 3'd3,
        SP_GAP  = 3'd4,
        SP_DONE = 3'd5
    } sp_state_t;

    function automatic logic [3:0] color_onehot(
        input logic [COLOR_W-1:0] c
    );
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/sequence_player_phase_timer.sv
// phase_timer: down-counter for one display phase.
// Ports: CLOCK, reset (async, high), load + len start a phase of len
// cycles (len >= 1), clear cancels it, done is high on its last cycle.
module phase_timer (
    input  logic        CLOCK,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] len,
    output logic        done
);

    logic [31:0] cnt;
    logic        active;

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            cnt    <= 32'd0;
            active <= 1'b0;
        end else if (clear) begin
            cnt    <= 32'd0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= len - 32'd1;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == 32'd0)
                active <= 1'b0;
            else
                cnt <= cnt - 32'd1;
        end
    end

    assign done = active && (cnt == 32'd0);

endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays the stored color sequence on the LEDs during
// the FPGA turn. Ports: CLOCK, reset (async, high), en (play level),
// round_len, speed (durations >> speed), mem_data/mem_addr (1-cycle
// synchronous memory), leds (one-hot), busy, end_FPGA.
module sequence_player
    import genius_pkg::*;
#(
    parameter int SEQ_LEN = 16,
    parameter int ADDR_W  = 4,
    parameter int ON_CYC  = 50_000_000,
    parameter int OFF_CYC = 25_000_000
) (
    input  logic               CLOCK,
    input  logic               reset,
    input  logic               en,
    input  logic [ADDR_W:0]    round_len,
    input  logic [1:0]         speed,
    input  logic [COLOR_W-1:0] mem_data,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [3:0]         leds,
    output logic               busy,
    output logic               end_FPGA
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(SEQ_LEN);
    localparam logic [31:0]     ON_W    = 32'(ON_CYC);
    localparam logic [31:0]     OFF_W   = 32'(OFF_CYC);

    sp_state_t state, state_n;

    logic [ADDR_W:0]   len_q, len_n;
    logic [31:0]       on_q, on_n;
    logic [31:0]       off_q, off_n;
    logic [ADDR_W-1:0] index_q, index_n;
    logic [ADDR_W-1:0] addr_n;
    logic [3:0]        leds_n;

    logic [ADDR_W:0]   clip_len;
    logic [31:0]       on_shift, off_shift;
    logic              t_load, t_clear, t_done, abort;
    logic [31:0]       t_len;

    // Start-of-round values, sampled only on the IDLE -> ADDR edge.
    assign clip_len  = (round_len > MAX_LEN) ? MAX_LEN : round_len;
    assign on_shift  = ON_W >> speed;
    assign off_shift = OFF_W >> speed;

    phase_timer u_timer (
        .CLOCK (CLOCK),
        .reset (reset),
        .load  (t_load),
        .clear (t_clear),
        .len   (t_len),
        .done  (t_done)
    );

    always_comb begin
        state_n = state;
        len_n   = len_q;
        on_n    = on_q;
        off_n   = off_q;
        index_n = index_q;
        addr_n  = mem_addr;
        leds_n  = leds;
        t_load  = 1'b0;
        t_clear = 1'b0;
        t_len   = on_q;
        abort   = 1'b0;

        unique case (state)
            SP_IDLE: begin
                leds_n = 4'b0000;
                if (en) begin
                    len_n   = clip_len;
                    on_n    = (on_shift == 32'd0) ? 32'd1 : on_shift;
                    off_n   = (off_shift == 32'd0) ? 32'd1 : off_shift;
                    index_n = '0;
                    if (clip_len == '0) begin
                        state_n = SP_DONE;
                    end else begin
                        state_n = SP_ADDR;
                        addr_n  = '0;
                    end
                end
            end
            SP_ADDR: begin
                abort   = !en;
                state_n = SP_WAIT;
            end
            SP_WAIT: begin
                abort   = !en;
                state_n = SP_SHOW;
                leds_n  = color_onehot(mem_data);
                t_load  = 1'b1;
                t_len   = on_q;
            end
            SP_SHOW: begin
                abort = !en;
                if (t_done) begin
                    state_n = SP_GAP;
                    leds_n  = 4'b0000;
                    t_load  = 1'b1;
                    t_len   = off_q;
                end
            end
            SP_GAP: begin
                abort = !en;
                if (t_done) begin
                    if ({1'b0, index_q} == len_q - 1'b1) begin
                        state_n = SP_DONE;
                    end else begin
                        index_n = index_q + 1'b1;
                        addr_n  = index_q + 1'b1;
                        state_n = SP_ADDR;
                    end
                end
            end
            SP_DONE: begin
                leds_n = 4'b0000;
                if (!en)
                    state_n = SP_IDLE;
            end
            default: begin
                state_n = SP_IDLE;
                leds_n  = 4'b0000;
            end
        endcase

        // Losing en mid-play drops everything without signalling done.
        if (abort) begin
            state_n = SP_IDLE;
            leds_n  = 4'b0000;
            index_n = '0;
            addr_n  = mem_addr;
            t_load  = 1'b0;
            t_clear = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state    <= SP_IDLE;
            len_q    <= '0;
            on_q     <= 32'd1;
            off_q    <= 32'd1;
            index_q  <= '0;
            mem_addr <= '0;
            leds     <= 4'b0000;
            busy     <= 1'b0;
            end_FPGA <= 1'b0;
        end else begin
            state    <= state_n;
            len_q    <= len_n;
            on_q     <= on_n;
            off_q    <= off_n;
            index_q  <= index_n;
            mem_addr <= addr_n;
            leds     <= leds_n;
            busy     <= (state_n != SP_IDLE) && (state_n != SP_DONE);
            end_FPGA <= (state_n == SP_DONE);
        end
    end

endmodule
